// File: rtl/palette_pipeline_if.sv
// Pixel, palette-write and fade bundle between the sprite/game logic
// and the palette pipeline that drives the VGA DAC.
interface palette_pipeline_if #(
  parameter int IDX_W   = 5,
  parameter int COLOR_W = 8
) ();
  logic                   frame_start;
  logic                   pix_valid;
  logic                   is_chooser;
  logic                   is_text;
  logic                   text_bit;
  logic                   is_background;
  logic [IDX_W-1:0]       palette_idx;
  logic                   wr_en;
  logic [IDX_W-1:0]       wr_idx;
  logic [3*COLOR_W-1:0]   wr_rgb;
  logic                   fade_req;
  logic                   fade_dir;
  logic                   fade_busy;
  logic                   out_valid;
  logic [COLOR_W-1:0]     VGA_R;
  logic [COLOR_W-1:0]     VGA_G;
  logic [COLOR_W-1:0]     VGA_B;

  modport master (
    output frame_start, pix_valid, is_chooser, is_text,
    output text_bit, is_background, palette_idx,
    output wr_en, wr_idx, wr_rgb, fade_req, fade_dir,
    input  fade_busy, out_valid, VGA_R, VGA_G, VGA_B
  );

  modport slave (
    input  frame_start, pix_valid, is_chooser, is_text,
    input  text_bit, is_background, palette_idx,
    input  wr_en, wr_idx, wr_rgb, fade_req, fade_dir,
    output fade_busy, out_valid, VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/palette_pipeline.sv
// Two-stage palette lookup with writable palette, chooser blink
// and frame-synchronous fade-to/from-black.
module palette_pipeline #(
  parameter int IDX_W        = 5,
  parameter int COLOR_W      = 8,
  parameter int FADE_SHIFT   = 4,
  parameter int BLINK_FRAMES = 30,
  parameter int CHOOSER_IDX  = 2
) (
  input logic             Clk,
  input logic             Reset_n,
  palette_pipeline_if.slave bus
);

  localparam int N      = 2**IDX_W;
  localparam int RGB_W  = 3*COLOR_W;
  localparam int LVL_W  = FADE_SHIFT+1;
  localparam int PROD_W = COLOR_W+FADE_SHIFT+1;
  localparam int CNT_W  = $clog2(BLINK_FRAMES+1);

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(2**FADE_SHIFT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES-1);
  localparam logic [IDX_W-1:0] IDX_CH   = IDX_W'(CHOOSER_IDX);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;

  typedef logic [RGB_W-1:0] rgb_t;
  typedef enum logic {S_IDLE, S_FADING} fade_state_e;

  rgb_t             pal_q [N];
  rgb_t             pal_d [N];
  rgb_t             c1_q, c1_d;
  logic             v1_q, v1_d;
  rgb_t             rgb2_q, rgb2_d;
  logic             v2_q, v2_d;
  fade_state_e      state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] target_q, target_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  function automatic logic [COLOR_W-1:0] scale(
    input logic [COLOR_W-1:0] c,
    input logic [LVL_W-1:0]   l
  );
    logic [PROD_W-1:0] p;
    p = PROD_W'(c) * PROD_W'(l);
    return COLOR_W'(p >> FADE_SHIFT);
  endfunction

  // Stage-1 reads see the pre-write palette in a write cycle.
  always_comb begin
    pal_d = pal_q;
    if (bus.wr_en) pal_d[bus.wr_idx] = bus.wr_rgb;
  end

  always_comb begin
    c1_d = pal_q[bus.palette_idx];
    if (bus.is_chooser)
      c1_d = phase_q ? pal_q[IDX_CH] : '0;
    else if (bus.is_text)
      c1_d = bus.text_bit ? pal_q[IDX_ONE]
                          : pal_q[IDX_ZERO];
    else if (bus.is_background)
      c1_d = pal_q[IDX_ZERO];
    v1_d = bus.pix_valid;
  end

  always_comb begin
    rgb2_d = {
      scale(c1_q[2*COLOR_W +: COLOR_W], level_q),
      scale(c1_q[COLOR_W   +: COLOR_W], level_q),
      scale(c1_q[0         +: COLOR_W], level_q)
    };
    v2_d = v1_q;
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    target_d = target_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.fade_req) begin
          state_d  = S_FADING;
          target_d = bus.fade_dir ? LVL_FULL : '0;
        end
      end
      S_FADING: begin
        if (bus.frame_start) begin
          if (level_q == target_q) begin
            state_d = S_IDLE;
          end else begin
            level_d = (level_q < target_q)
                    ? level_q + LVL_W'(1)
                    : level_q - LVL_W'(1);
            if (level_d == target_q) state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_FADING);
  end

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (bus.frame_start) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N; i++)
        pal_q[i] <= (i == 1) ? {RGB_W{1'b0}}
                             : {RGB_W{1'b1}};
      c1_q     <= '0;
      v1_q     <= 1'b0;
      rgb2_q   <= '0;
      v2_q     <= 1'b0;
      state_q  <= S_IDLE;
      level_q  <= LVL_FULL;
      target_q <= LVL_FULL;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
    end else begin
      pal_q    <= pal_d;
      c1_q     <= c1_d;
      v1_q     <= v1_d;
      rgb2_q   <= rgb2_d;
      v2_q     <= v2_d;
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  assign bus.VGA_R     = rgb2_q[2*COLOR_W +: COLOR_W];
  assign bus.VGA_G     = rgb2_q[COLOR_W   +: COLOR_W];
  assign bus.VGA_B     = rgb2_q[0         +: COLOR_W];
  assign bus.out_valid = v2_q;
  assign bus.fade_busy = busy_q;

endmodule

// File: tb/tb_palette_pipeline.sv
// Directed bench for palette_pipeline: palette writes, flag priority,
// chooser blink, fades and reset.
module tb_palette_pipeline;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  palette_pipeline_if #(.IDX_W(5), .COLOR_W(8)) bus ();

  palette_pipeline dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus.slave)
  );

  logic [23:0] rgb;
  assign rgb = {bus.VGA_R, bus.VGA_G, bus.VGA_B};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic set_pix(input logic ch, input logic tx,
                         input logic tb_, input logic bg,
                         input logic [4:0] idx);
    bus.pix_valid     = 1'b1;
    bus.is_chooser    = ch;
    bus.is_text       = tx;
    bus.text_bit      = tb_;
    bus.is_background = bg;
    bus.palette_idx   = idx;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [23:0] v);
    bus.wr_en  = 1'b1;
    bus.wr_idx = idx;
    bus.wr_rgb = v;
    tick();
    bus.wr_en  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (rgb !== 24'h000000) begin
      failures++;
      $display("FAIL reset_rgb got=%h exp=000000", rgb);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.fade_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", bus.fade_busy);
    end
    rst_n = 1'b1;
    tick();
    set_pix(0, 0, 0, 0, 5'd1);
    tick(); tick();
    checks++;
    if (rgb !== 24'h000000 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL idx1_black got=%h/%b exp=000000/1",
               rgb, bus.out_valid);
    end
    set_pix(0, 0, 0, 0, 5'd3);
    tick(); tick();
    checks++;
    if (rgb !== 24'hFFFFFF) begin
      failures++;
      $display("FAIL idx3_white got=%h exp=FFFFFF", rgb);
    end
    bus.pix_valid = 1'b0;
    tick(); tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL valid_low got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_write();
    set_pix(0, 0, 0, 0, 5'd5);
    wr(5'd5, 24'h42CE5A);
    tick();
    checks++;
    if (rgb !== 24'hFFFFFF) begin
      failures++;
      $display("FAIL wr_same_cycle got=%h exp=FFFFFF", rgb);
    end
    tick();
    checks++;
    if (rgb !== 24'h42CE5A) begin
      failures++;
      $display("FAIL wr_next got=%h exp=42CE5A", rgb);
    end
    wr(5'd0, 24'h112233);
    set_pix(0, 0, 0, 1, 5'd7);
    tick(); tick();
    checks++;
    if (rgb !== 24'h112233) begin
      failures++;
      $display("FAIL background got=%h exp=112233", rgb);
    end
    set_pix(0, 1, 1, 1, 5'd7);
    tick(); tick();
    checks++;
    if (rgb !== 24'h000000) begin
      failures++;
      $display("FAIL text_fg got=%h exp=000000", rgb);
    end
    set_pix(0, 1, 0, 0, 5'd7);
    tick(); tick();
    checks++;
    if (rgb !== 24'h112233) begin
      failures++;
      $display("FAIL text_bg got=%h exp=112233", rgb);
    end
  endtask

  task automatic test_chooser();
    set_pix(1, 1, 1, 1, 5'd3);
    tick(); tick();
    checks++;
    if (rgb !== 24'h000000) begin
      failures++;
      $display("FAIL chooser_off0 got=%h exp=000000", rgb);
    end
    repeat (29) frame();
    tick(); tick();
    checks++;
    if (rgb !== 24'h000000) begin
      failures++;
      $display("FAIL chooser_off29 got=%h exp=000000", rgb);
    end
    wr(5'd2, 24'hD63100);
    frame();
    tick(); tick();
    checks++;
    if (rgb !== 24'hD63100) begin
      failures++;
      $display("FAIL chooser_on0 got=%h exp=D63100", rgb);
    end
    repeat (29) frame();
    tick(); tick();
    checks++;
    if (rgb !== 24'hD63100) begin
      failures++;
      $display("FAIL chooser_on29 got=%h exp=D63100", rgb);
    end
    frame();
    tick(); tick();
    checks++;
    if (rgb !== 24'h000000) begin
      failures++;
      $display("FAIL chooser_back got=%h exp=000000", rgb);
    end
  endtask

  task automatic test_fade_out();
    set_pix(0, 0, 0, 0, 5'd3);
    tick(); tick();
    bus.fade_req = 1'b1;
    bus.fade_dir = 1'b0;
    tick();
    bus.fade_req = 1'b0;
    checks++;
    if (bus.fade_busy !== 1'b1) begin
      failures++;
      $display("FAIL fo_busy got=%b exp=1", bus.fade_busy);
    end
    frame();
    tick(); tick();
    // 255*15 >> 4 = 239
    checks++;
    if (rgb !== 24'hEFEFEF) begin
      failures++;
      $display("FAIL fo_lvl15 got=%h exp=EFEFEF", rgb);
    end
    repeat (7) frame();
    tick(); tick();
    checks++;
    if (rgb !== 24'h7F7F7F) begin
      failures++;
      $display("FAIL fo_lvl8 got=%h exp=7F7F7F", rgb);
    end
    bus.fade_req = 1'b1;
    bus.fade_dir = 1'b1;
    tick();
    bus.fade_req = 1'b0;
    repeat (7) frame();
    tick(); tick();
    checks++;
    if (rgb !== 24'h0F0F0F || bus.fade_busy !== 1'b1) begin
      failures++;
      $display("FAIL fo_lvl1 got=%h/%b exp=0F0F0F/1",
               rgb, bus.fade_busy);
    end
    frame();
    checks++;
    if (bus.fade_busy !== 1'b0) begin
      failures++;
      $display("FAIL fo_done_busy got=%b exp=0", bus.fade_busy);
    end
    tick(); tick();
    checks++;
    if (rgb !== 24'h000000) begin
      failures++;
      $display("FAIL fo_black got=%h exp=000000", rgb);
    end
    repeat (3) frame();
    tick(); tick();
    checks++;
    if (rgb !== 24'h000000) begin
      failures++;
      $display("FAIL fo_hold got=%h exp=000000", rgb);
    end
  endtask

  task automatic test_fade_in_coincident();
    bus.fade_req    = 1'b1;
    bus.fade_dir    = 1'b1;
    bus.frame_start = 1'b1;
    tick();
    bus.fade_req    = 1'b0;
    bus.frame_start = 1'b0;
    checks++;
    if (bus.fade_busy !== 1'b1) begin
      failures++;
      $display("FAIL fi_busy got=%b exp=1", bus.fade_busy);
    end
    tick(); tick();
    checks++;
    if (rgb !== 24'h000000) begin
      failures++;
      $display("FAIL fi_nostep got=%h exp=000000", rgb);
    end
    frame();
    tick(); tick();
    checks++;
    if (rgb !== 24'h0F0F0F) begin
      failures++;
      $display("FAIL fi_lvl1 got=%h exp=0F0F0F", rgb);
    end
    repeat (7) frame();
    tick(); tick();
    checks++;
    if (rgb !== 24'h7F7F7F) begin
      failures++;
      $display("FAIL fi_lvl8 got=%h exp=7F7F7F", rgb);
    end
  endtask

  task automatic test_reset_mid_fade();
    rst_n = 1'b0;
    #1;
    checks++;
    if (rgb !== 24'h000000 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_out got=%h/%b exp=000000/0",
               rgb, bus.out_valid);
    end
    checks++;
    if (bus.fade_busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_busy got=%b exp=0", bus.fade_busy);
    end
    tick();
    rst_n = 1'b1;
    set_pix(0, 0, 0, 0, 5'd5);
    tick(); tick();
    checks++;
    if (rgb !== 24'hFFFFFF || bus.fade_busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_idx5 got=%h/%b exp=FFFFFF/0",
               rgb, bus.fade_busy);
    end
    set_pix(0, 0, 0, 1, 5'd5);
    tick(); tick();
    checks++;
    if (rgb !== 24'hFFFFFF) begin
      failures++;
      $display("FAIL rst_entry0 got=%h exp=FFFFFF", rgb);
    end
    set_pix(0, 1, 1, 0, 5'd5);
    tick(); tick();
    checks++;
    if (rgb !== 24'h000000) begin
      failures++;
      $display("FAIL rst_entry1 got=%h exp=000000", rgb);
    end
  endtask

  task automatic test_fade_noop();
    set_pix(0, 0, 0, 0, 5'd3);
    bus.fade_req = 1'b1;
    bus.fade_dir = 1'b1;
    tick();
    bus.fade_req = 1'b0;
    checks++;
    if (bus.fade_busy !== 1'b1) begin
      failures++;
      $display("FAIL noop_busy got=%b exp=1", bus.fade_busy);
    end
    frame();
    checks++;
    if (bus.fade_busy !== 1'b0) begin
      failures++;
      $display("FAIL noop_exit got=%b exp=0", bus.fade_busy);
    end
    tick(); tick();
    checks++;
    if (rgb !== 24'hFFFFFF) begin
      failures++;
      $display("FAIL noop_full got=%h exp=FFFFFF", rgb);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bus.frame_start   = 1'b0;
    bus.pix_valid     = 1'b0;
    bus.is_chooser    = 1'b0;
    bus.is_text       = 1'b0;
    bus.text_bit      = 1'b0;
    bus.is_background = 1'b0;
    bus.palette_idx   = '0;
    bus.wr_en         = 1'b0;
    bus.wr_idx        = '0;
    bus.wr_rgb        = '0;
    bus.fade_req      = 1'b0;
    bus.fade_dir      = 1'b0;
    test_reset();
    test_write();
    test_chooser();
    test_fade_out();
    test_fade_in_coincident();
    test_reset_mid_fade();
    test_fade_noop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
